// File: rtl/booth_product_accumulator.sv
// Accumulates fixed-size batches of signed Booth products into a wider signed sum with valid/ready on both sides.
// Optional macro SATURATE_EN clamps the running sum on signed overflow instead of wrapping.
module booth_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int BATCH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  // The counter only has to reach BATCH-1; a batch of one keeps it pinned at zero.
  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovfAcc_q, ovfAcc_d;
  logic               outValid_q, outValid_d;
  logic [ACC_W-1:0]   outSum_q, outSum_d;
  logic               outOvf_q, outOvf_d;

  logic [ACC_W-1:0]   prodExt;
  logic [ACC_W-1:0]   sumRaw;
  logic [ACC_W-1:0]   accNext;
  logic               ovfThis;
  logic               accept;
  logic               lastProduct;

  assign prodExt = ACC_W'($signed(in_product));
  assign sumRaw  = acc_q + prodExt;
  assign ovfThis = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) &&
                   (sumRaw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SATURATE_EN
  // Both operands share a sign on overflow, so the accumulator sign picks the rail.
  assign accNext = ovfThis ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sumRaw;
`else
  assign accNext = sumRaw;
`endif

  assign in_ready    = (state_q != HOLD) && !clear;
  assign accept      = in_valid && in_ready;
  assign lastProduct = (cnt_q == LAST_CNT);

  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_ovf   = outOvf_q;

  // IDLE and ACCUM share one path: acc is zero in IDLE, so accNext is the plain extended product.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovfAcc_d   = ovfAcc_q;
    outValid_d = outValid_q;
    outSum_d   = outSum_q;
    outOvf_d   = outOvf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (clear) begin
          acc_d    = '0;
          cnt_d    = '0;
          ovfAcc_d = 1'b0;
          state_d  = IDLE;
        end else if (accept) begin
          if (lastProduct) begin
            outSum_d   = accNext;
            outOvf_d   = ovfAcc_q | ovfThis;
            outValid_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            ovfAcc_d   = 1'b0;
            state_d    = HOLD;
          end else begin
            acc_d    = accNext;
            cnt_d    = cnt_q + CNT_W'(1);
            ovfAcc_d = ovfAcc_q | ovfThis;
            state_d  = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovfAcc_q   <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovfAcc_q   <= ovfAcc_d;
      outValid_q <= outValid_d;
      outSum_q   <= outSum_d;
      outOvf_q   <= outOvf_d;
    end
  end

endmodule
